// File: rtl/bus_xfer_ctrl.sv
// Transfer sequencer for the bus-attached general registers: MOV, LDI and optional SWAP.
// Define SWAP_XFER_EN to enable the three-cycle SWAP command (op 10) and its tmp register.
module bus_xfer_ctrl #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [IDX_W-1:0]    src,
    input  logic [IDX_W-1:0]    dst,
    input  logic [WIDTH-1:0]    imm,
    output logic [NUM_REGS-1:0] reg_read,
    output logic [NUM_REGS-1:0] reg_write,
    inout  logic [WIDTH-1:0]    bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                overrun
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE
`ifdef SWAP_XFER_EN
        ,
        SW1,
        SW2,
        SW3
`endif
    } state_t;

    state_t             state;
    logic               ldi_q;
    logic [IDX_W-1:0]   src_q;
    logic [IDX_W-1:0]   dst_q;
    logic [WIDTH-1:0]   imm_q;
    logic               drive_en;
    logic [WIDTH-1:0]   drive_val;
`ifdef SWAP_XFER_EN
    logic [WIDTH-1:0]   tmp;
`endif

    function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

`ifdef SWAP_XFER_EN
    assign drive_val = (state == SW3) ? tmp : imm_q;
`else
    assign drive_val = imm_q;
`endif

    // The only controller bus driver; enabled solely while no register is selected to read.
    assign bus = drive_en ? drive_val : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            reg_read  <= '0;
            reg_write <= '0;
            drive_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            overrun   <= 1'b0;
            ldi_q     <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            imm_q     <= '0;
`ifdef SWAP_XFER_EN
            tmp       <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (start && busy)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    reg_read  <= '0;
                    reg_write <= '0;
                    drive_en  <= 1'b0;
                    if (start) begin
                        src_q <= src;
                        dst_q <= dst;
                        imm_q <= imm;
                        ldi_q <= (op == 2'b01);
                        case (op)
                            2'b00: begin
                                state    <= SETUP;
                                busy     <= 1'b1;
                                reg_read <= onehot(src);
                            end
                            2'b01: begin
                                state    <= SETUP;
                                busy     <= 1'b1;
                                drive_en <= 1'b1;
                            end
`ifdef SWAP_XFER_EN
                            2'b10: begin
                                state    <= SW1;
                                busy     <= 1'b1;
                                reg_read <= onehot(src);
                            end
`endif
                            default: err <= 1'b1;
                        endcase
                    end
                end

                SETUP: begin
                    state     <= WRITE;
                    reg_read  <= ldi_q ? '0 : onehot(src_q);
                    drive_en  <= ldi_q;
                    reg_write <= onehot(dst_q);
                end

                WRITE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    reg_read  <= '0;
                    reg_write <= '0;
                    drive_en  <= 1'b0;
                end

`ifdef SWAP_XFER_EN
                SW1: begin
                    state     <= SW2;
                    tmp       <= bus;
                    reg_read  <= onehot(dst_q);
                    reg_write <= onehot(src_q);
                end

                SW2: begin
                    state     <= SW3;
                    reg_read  <= '0;
                    reg_write <= onehot(dst_q);
                    drive_en  <= 1'b1;
                end

                SW3: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    reg_write <= '0;
                    drive_en  <= 1'b0;
                end
`endif

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    reg_read  <= '0;
                    reg_write <= '0;
                    drive_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: a register file on the bus plus a value-level model of command effects.
module tb_bus_xfer_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [1:0]  src = '0;
    logic [1:0]  dst = '0;
    logic [15:0] imm = '0;
    logic [3:0]  reg_read;
    logic [3:0]  reg_write;
    wire  [15:0] bus;
    logic        busy, done, err, overrun;

    int checks = 0;
    int failures = 0;
    bit exp_ovr = 1'b0;

    logic [15:0] regs [4] = '{default: '0};
    logic [15:0] m    [4] = '{default: '0};
    logic [1:0]  rd_idx;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.WIDTH(16), .NUM_REGS(4), .IDX_W(2)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src(src), .dst(dst),
        .imm(imm), .reg_read(reg_read), .reg_write(reg_write), .bus(bus),
        .busy(busy), .done(done), .err(err), .overrun(overrun)
    );

    always_comb begin
        rd_idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (reg_read[i]) rd_idx = 2'(i);
    end

    assign bus = (reg_read != 4'b0) ? regs[rd_idx] : 16'bz;

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (reg_write[i]) regs[i] <= bus;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one legal command, checks every busy cycle and the done cycle; returns in the done cycle.
    task automatic run_cmd(input logic [1:0] o, input logic [1:0] s, input logic [1:0] d,
                           input logic [15:0] im, input bit poke);
        logic [3:0]  erd [3];
        logic [3:0]  ewr [3];
        logic [15:0] ebus [3];
        logic [15:0] vs, vd;
        logic [3:0]  bs, bd;
        int n;
        vs = m[s];
        vd = m[d];
        bs = 4'b0001 << s;
        bd = 4'b0001 << d;
        n  = (o == 2'b10) ? 3 : 2;
        if (o == 2'b00) begin
            erd[0] = bs; ewr[0] = 4'b0; ebus[0] = vs;
            erd[1] = bs; ewr[1] = bd;   ebus[1] = vs;
        end else if (o == 2'b01) begin
            erd[0] = 4'b0; ewr[0] = 4'b0; ebus[0] = im;
            erd[1] = 4'b0; ewr[1] = bd;   ebus[1] = im;
        end else begin
            erd[0] = bs;   ewr[0] = 4'b0; ebus[0] = vs;
            erd[1] = bd;   ewr[1] = bs;   ebus[1] = vd;
            erd[2] = 4'b0; ewr[2] = bd;   ebus[2] = vs;
        end
        start = 1'b1; op = o; src = s; dst = d; imm = im;
        tick();
        start = 1'b0;
        op = 2'($urandom); src = 2'($urandom); dst = 2'($urandom); imm = 16'($urandom);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (reg_read !== erd[k] || reg_write !== ewr[k]) begin
                failures++;
                $display("FAIL strobes op=%0d cyc=%0d rd=%b wr=%b want rd=%b wr=%b",
                         o, k, reg_read, reg_write, erd[k], ewr[k]);
            end
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL busy_phase op=%0d cyc=%0d busy=%b done=%b want 1 0", o, k, busy, done);
            end
            checks++;
            if (bus !== ebus[k]) begin
                failures++;
                $display("FAIL bus op=%0d cyc=%0d bus=%h want %h", o, k, bus, ebus[k]);
            end
            if (poke && k == 0) begin
                start = 1'b1;
                exp_ovr = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        if (o == 2'b00) m[d] = vs;
        else if (o == 2'b01) m[d] = im;
        else begin
            m[s] = vd;
            m[d] = vs;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || reg_read !== 4'b0 || reg_write !== 4'b0) begin
            failures++;
            $display("FAIL done_cycle op=%0d done=%b busy=%b rd=%b wr=%b want 1 0 0000 0000",
                     o, done, busy, reg_read, reg_write);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (regs[i] !== m[i]) begin
                failures++;
                $display("FAIL reg_value op=%0d R%0d=%h want %h", o, i, regs[i], m[i]);
            end
        end
        checks++;
        if (overrun !== exp_ovr) begin
            failures++;
            $display("FAIL overrun_flag overrun=%b want %b", overrun, exp_ovr);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; op = 2'b01; dst = 2'd1; imm = 16'hFFFF;
        tick(); tick();
        checks++;
        if (reg_read !== 4'b0 || reg_write !== 4'b0 || busy !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_state rd=%b wr=%b busy=%b done=%b err=%b ovr=%b want all 0",
                     reg_read, reg_write, busy, done, err, overrun);
        end
        reset = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || reg_read !== 4'b0 || reg_write !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b rd=%b wr=%b want 0", busy, reg_read, reg_write);
        end
        exp_ovr = 1'b0;
    endtask

    task automatic test_ldi;
        run_cmd(2'b01, 2'd0, 2'd1, 16'h1234, 1'b0);
        tick();
        run_cmd(2'b01, 2'd0, 2'd0, 16'hAAAA, 1'b0);
        run_cmd(2'b01, 2'd3, 2'd2, 16'h5555, 1'b0);
        run_cmd(2'b01, 2'd1, 2'd3, 16'h0F0F, 1'b0);
    endtask

    task automatic test_mov;
        tick();
        run_cmd(2'b00, 2'd1, 2'd3, 16'h0000, 1'b0);
        checks++;
        if (regs[3] !== 16'h1234) begin
            failures++;
            $display("FAIL mov_r3 R3=%h want 1234", regs[3]);
        end
        run_cmd(2'b00, 2'd2, 2'd2, 16'h0000, 1'b0);
    endtask

    task automatic test_illegal;
        logic [1:0] bad [2];
        int nbad;
        bad[0] = 2'b11;
        bad[1] = 2'b10;
`ifdef SWAP_XFER_EN
        nbad = 1;
`else
        nbad = 2;
`endif
        for (int b = 0; b < nbad; b++) begin
            start = 1'b1; op = bad[b]; src = 2'd1; dst = 2'd0; imm = 16'hDEAD;
            tick();
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || reg_read !== 4'b0 || reg_write !== 4'b0) begin
                failures++;
                $display("FAIL illegal_op op=%b err=%b busy=%b done=%b rd=%b wr=%b want 1 0 0 0000 0000",
                         bad[b], err, busy, done, reg_read, reg_write);
            end
            tick();
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || reg_write !== 4'b0) begin
                failures++;
                $display("FAIL illegal_after op=%b err=%b busy=%b done=%b wr=%b want 0 0 0 0000",
                         bad[b], err, busy, done, reg_write);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (regs[i] !== m[i]) begin
                failures++;
                $display("FAIL illegal_regs R%0d=%h want %h", i, regs[i], m[i]);
            end
        end
    endtask

`ifdef SWAP_XFER_EN
    task automatic test_swap;
        tick();
        run_cmd(2'b10, 2'd0, 2'd2, 16'h0000, 1'b0);
        checks++;
        if (regs[0] !== 16'h5555 || regs[2] !== 16'hAAAA) begin
            failures++;
            $display("FAIL swap_values R0=%h R2=%h want 5555 aaaa", regs[0], regs[2]);
        end
        run_cmd(2'b10, 2'd1, 2'd1, 16'h0000, 1'b0);
    endtask
`endif

    task automatic test_back_to_back;
        logic [1:0] o;
        for (int t = 0; t < 40; t++) begin
`ifdef SWAP_XFER_EN
            o = 2'($urandom_range(0, 2));
`else
            o = 2'($urandom_range(0, 1));
`endif
            run_cmd(o, 2'($urandom), 2'($urandom), 16'($urandom), 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
    endtask

    task automatic test_overrun;
        tick();
        run_cmd(2'b00, 2'd0, 2'd1, 16'h0000, 1'b1);
        tick(); tick(); tick();
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL overrun_sticky overrun=%b busy=%b want 1 0", overrun, busy);
        end
        run_cmd(2'b01, 2'd0, 2'd2, 16'hC0DE, 1'b0);
    endtask

    task automatic test_reset_mid;
        // Reset taken on the edge leaving SETUP: the write cycle never happens.
        tick();
        start = 1'b1; op = 2'b00; src = 2'd2; dst = 2'd3; imm = '0;
        tick();
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ovr = 1'b0;
        checks++;
        if (reg_read !== 4'b0 || reg_write !== 4'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_setup rd=%b wr=%b busy=%b ovr=%b want 0", reg_read, reg_write, busy, overrun);
        end
        tick();
        checks++;
        if (done !== 1'b0 || regs[3] !== m[3]) begin
            failures++;
            $display("FAIL reset_setup_after done=%b R3=%h want 0 %h", done, regs[3], m[3]);
        end
        // Reset taken on the capture edge: capture completes, but no done follows.
        start = 1'b1; op = 2'b00; src = 2'd2; dst = 2'd0; imm = '0;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m[0] = m[2];
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || reg_read !== 4'b0 || reg_write !== 4'b0) begin
            failures++;
            $display("FAIL reset_write done=%b busy=%b rd=%b wr=%b want 0", done, busy, reg_read, reg_write);
        end
        tick();
        checks++;
        if (done !== 1'b0 || regs[0] !== m[0]) begin
            failures++;
            $display("FAIL reset_write_after done=%b R0=%h want 0 %h", done, regs[0], m[0]);
        end
        run_cmd(2'b00, 2'd0, 2'd1, 16'h0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_mov();
        test_illegal();
`ifdef SWAP_XFER_EN
        test_swap();
`endif
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Sequencer directly upstream of the bus-attached 16-bit general registers.
- Turns one transfer command into the per-register read (bus drive) and write (bus capture) strobes those registers consume.
- Drives the shared tri-state bus itself for immediate loads and swap write-back.
- Guarantees at most one bus driver in any cycle and a fixed, known latency per command.

Parameters:
- WIDTH, 16, bus and data width in bits.
- NUM_REGS, 4, number of bus registers; indices 0..NUM_REGS-1.
- IDX_W, 2, width of a register index; must equal ceil(log2(NUM_REGS)).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command request; sampled only at a rising edge.
- op  input  2  00 MOV, 01 LDI, 10 SWAP, 11 reserved.
- src  input  IDX_W  source register (MOV), first register (SWAP).
- dst  input  IDX_W  destination register (MOV/LDI), second register (SWAP).
- imm  input  WIDTH  immediate value for LDI.
- reg_read  output  NUM_REGS  one-hot (or zero) bus-drive enables to the registers.
- reg_write  output  NUM_REGS  one-hot (or zero) capture enables to the registers.
- bus  inout  WIDTH  shared data bus; the controller drives it only when stated below, else high-Z.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse after the final write cycle.
- err  output  1  one-cycle pulse when an illegal op is rejected.
- overrun  output  1  sticky flag; set when start is high while busy.

Behaviour:
- Reset (synchronous):
  - At a rising edge with reset=1: state=IDLE; reg_read=0, reg_write=0, busy=0, done=0, err=0, overrun=0, tmp=0; bus released.
  - Reset wins over start in the same edge.
  - A command interrupted by reset is abandoned; any write cycle not yet reached never occurs.
- Command acceptance:
  - A command is accepted at an edge where state=IDLE, reset=0, start=1 and op is legal.
  - op, src, dst and imm are latched at acceptance; later changes on those inputs have no effect on the running command.
  - Illegal op (11, or 10 without SWAP_XFER_EN): not accepted; err=1 for the next cycle; state stays IDLE; no strobes.
  - start=1 while busy=1: ignored; overrun set and held until reset.
- States: IDLE, SETUP, WRITE, SW1, SW2, SW3.
  - Strobes are decoded from the registered state and latched fields only, never from live inputs.
- MOV and LDI, two busy cycles:
  - Accept at edge E0 -> SETUP (cycle after E0).
    - MOV: reg_read[src]=1.
    - LDI: controller drives imm onto bus, reg_read=0.
    - reg_write=0.
  - E1 -> WRITE: same drive as SETUP, plus reg_write[dst]=1. The destination captures at E2.
  - E2 -> IDLE: done=1 for this cycle, busy=0.
  - A new start in this done cycle is accepted normally, giving back-to-back commands with no dead cycle.
  - MOV with src==dst executes normally; the register is rewritten with its own value.
- SWAP (SWAP_XFER_EN only), three busy cycles:
  - SW1: reg_read[src]=1; tmp <= bus at the end of the cycle.
  - SW2: reg_read[dst]=1, reg_write[src]=1.
  - SW3: controller drives tmp onto bus, reg_write[dst]=1.
  - Then IDLE with done=1.
  - src==dst: executes all three cycles; the register value is unchanged.
- Bus exclusivity:
  - At most one bit of reg_read is set, and never together with controller bus drive.
  - In IDLE, reg_read=0, reg_write=0 and the controller's bus driver is high-Z.
- busy=1 in exactly SETUP, WRITE, SW1, SW2 and SW3.

Optional Feature:
- Macro SWAP_XFER_EN.
- Defined: op 10 performs the SWAP sequence above; includes the WIDTH-bit tmp register and states SW1–SW3.
- Undefined: tmp and SW states are absent; op 10 is illegal (err pulse, no strobes, no done).

Test Plan:
- Reset, then preload R1=16'h1234 via LDI dst=1 imm=16'h1234 -> reg_write[1] high exactly one cycle, two cycles after accept; done pulse on the third cycle; R1 reads 16'h1234.
- MOV src=1 dst=3 with R1=16'h1234 -> SETUP reg_read=0010/reg_write=0000, WRITE reg_read=0010/reg_write=1000; R3=16'h1234; bus never driven by two sources.
- Back-to-back: new start during the done cycle of a MOV -> accepted immediately; start raised mid-command -> ignored, overrun=1 and stays 1 until reset.
- op=11 while IDLE -> err pulses one cycle; busy, done and all strobes stay 0. Same for op=10 when SWAP_XFER_EN is undefined.
- SWAP (SWAP_XFER_EN) R0=16'hAAAA, R2=16'h5555, src=0 dst=2 -> three busy cycles; afterwards R0=16'h5555, R2=16'hAAAA.
- Reset asserted in WRITE of a MOV -> strobes 0 and state IDLE from the next cycle; destination register unchanged if reset precedes the capture edge; no done pulse.
